// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   - ADDR_W / OPC_W    : default PC/offset and opcode field widths
//   - seq_state_e       : sequencer state encoding (also exported on the debug state port)
//   - OP_*              : opcode constants decoded in the DECODE state
package pc_seq_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned OPC_W  = 4;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExec    = 3'd2,
        StMemwait = 3'd3,
        StPcupd   = 3'd4,
        StHalt    = 3'd5
    } seq_state_e;

    localparam logic [OPC_W-1:0] OP_ALU = 4'h0;
    localparam logic [OPC_W-1:0] OP_LD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ST  = 4'h2;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h3;
    localparam logic [OPC_W-1:0] OP_BEQ = 4'h4;
    localparam logic [OPC_W-1:0] OP_BLT = 4'h5;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: bundle between the sequencer and its surroundings (IR/flags, memory, PC register).
//   inputs to sequencer : opcode, offset, zero_flag, neg_flag, mem_ready
//   outputs             : mem_read, mem_write, ir_load, pc_enable, pc_clear, addr_select,
//                         jump_offset, halted, state (+ err_timeout when PC_SEQ_WATCHDOG_EN)
//   modport master = sequencer side, modport slave = environment side.
interface pc_seq_if;
    import pc_seq_pkg::*;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] offset;
    logic              zero_flag;
    logic              neg_flag;
    logic              mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic              ir_load;
    logic              pc_enable;
    logic              pc_clear;
    logic              addr_select;
    logic [ADDR_W-1:0] jump_offset;
    logic              halted;
    logic [2:0]        state;
`ifdef PC_SEQ_WATCHDOG_EN
    logic              err_timeout;
`endif

    modport master (
        input  opcode, offset, zero_flag, neg_flag, mem_ready,
`ifdef PC_SEQ_WATCHDOG_EN
        output err_timeout,
`endif
        output mem_read, mem_write, ir_load, pc_enable, pc_clear, addr_select, jump_offset,
        output halted, state
    );

    modport slave (
        output opcode, offset, zero_flag, neg_flag, mem_ready,
`ifdef PC_SEQ_WATCHDOG_EN
        input  err_timeout,
`endif
        input  mem_read, mem_write, ir_load, pc_enable, pc_clear, addr_select, jump_offset,
        input  halted, state
    );

endinterface

// File: rtl/pc_seq_branch_eval.sv
// pc_seq_branch_eval: combinational branch decision.
//   opcode_i, zero_flag_i, neg_flag_i -> take_branch_o
//   JMP always taken; BEQ taken on zero flag; BLT taken on negative flag; others never.
module pc_seq_branch_eval
    import pc_seq_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             zero_flag_i,
    input  logic             neg_flag_i,
    output logic             take_branch_o
);

    always_comb begin
        take_branch_o = 1'b0;
        unique case (opcode_i)
            OP_JMP:  take_branch_o = 1'b1;
            OP_BEQ:  take_branch_o = zero_flag_i;
            OP_BLT:  take_branch_o = neg_flag_i;
            default: take_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller for the 12-bit PC datapath.
//   clk   : clock, all state changes on the rising edge
//   clear : asynchronous active-high reset
//   bus   : pc_seq_if.master (IR opcode/offset, flags, memory handshake, PC controls, debug)
// All outputs are registered so the negedge-sampled PC register sees stable values.
// Optional build macro PC_SEQ_WATCHDOG_EN adds a mem_ready wait watchdog and err_timeout.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic      clk,
    input logic      clear,
    pc_seq_if.master bus
);

    seq_state_e        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              ir_load_q, ir_load_d;
    logic              pc_enable_q, pc_enable_d;
    logic              pc_clear_q, pc_clear_d;
    logic              addr_select_q, addr_select_d;
    logic [ADDR_W-1:0] jump_offset_q, jump_offset_d;
    logic              halted_q, halted_d;
    logic              take_branch;
    logic              mem_ack;

`ifdef PC_SEQ_WATCHDOG_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WaitW-1:0] wait_q, wait_d;
    logic             err_timeout_q, err_timeout_d;
`endif

    pc_seq_branch_eval u_branch_eval (
        .opcode_i      (bus.opcode),
        .zero_flag_i   (bus.zero_flag),
        .neg_flag_i    (bus.neg_flag),
        .take_branch_o (take_branch)
    );

    // A request counts only if the strobe was already high when mem_ready is sampled.
    assign mem_ack = (mem_read_q | mem_write_q) & bus.mem_ready;

    always_comb begin
        state_d       = state_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        ir_load_d     = 1'b0;
        pc_enable_d   = 1'b0;
        pc_clear_d    = 1'b0;
        addr_select_d = 1'b0;
        jump_offset_d = '0;
        halted_d      = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (mem_ack) begin
                    state_d   = StDecode;
                    ir_load_d = 1'b1;
                end else begin
                    mem_read_d = 1'b1;
                end
            end
            StDecode: begin
                unique case (bus.opcode)
                    OP_LD: begin
                        state_d    = StMemwait;
                        mem_read_d = 1'b1;
                    end
                    OP_ST: begin
                        state_d     = StMemwait;
                        mem_write_d = 1'b1;
                    end
                    OP_JMP, OP_BEQ, OP_BLT: begin
                        // Flags and offset are captured here for the PCUPD cycle.
                        state_d       = StPcupd;
                        pc_enable_d   = 1'b1;
                        addr_select_d = take_branch;
                        jump_offset_d = take_branch ? bus.offset : '0;
                    end
                    OP_HLT: begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                state_d     = StPcupd;
                pc_enable_d = 1'b1;
            end
            StMemwait: begin
                if (mem_ack) begin
                    state_d     = StPcupd;
                    pc_enable_d = 1'b1;
                end else begin
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                end
            end
            StPcupd: begin
                state_d    = StFetch;
                mem_read_d = 1'b1;
            end
            StHalt:  halted_d = 1'b1;
            default: state_d = StFetch;
        endcase

`ifdef PC_SEQ_WATCHDOG_EN
        wait_d        = '0;
        err_timeout_d = err_timeout_q;
        if ((state_q == StFetch || state_q == StMemwait) && state_d == state_q) begin
            if (wait_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                state_d       = StHalt;
                mem_read_d    = 1'b0;
                mem_write_d   = 1'b0;
                halted_d      = 1'b1;
                err_timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= StFetch;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            ir_load_q     <= 1'b0;
            pc_enable_q   <= 1'b0;
            pc_clear_q    <= 1'b1;
            addr_select_q <= 1'b0;
            jump_offset_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            ir_load_q     <= ir_load_d;
            pc_enable_q   <= pc_enable_d;
            pc_clear_q    <= pc_clear_d;
            addr_select_q <= addr_select_d;
            jump_offset_q <= jump_offset_d;
            halted_q      <= halted_d;
        end
    end

`ifdef PC_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wait_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.err_timeout = err_timeout_q;
`endif

    assign bus.state       = state_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.ir_load     = ir_load_q;
    assign bus.pc_enable   = pc_enable_q;
    assign bus.pc_clear    = pc_clear_q;
    assign bus.addr_select = addr_select_q;
    assign bus.jump_offset = jump_offset_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// The bench plays the memory (per-request latency, random mem_ready noise while idle) and the
// negedge PC register; each instruction is checked against expected latency, strobe counts,
// jump decision and resulting PC computed from the instruction semantics.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic clear;

    pc_seq_if bus();

    pc_sequencer dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          hi_cnt = 0;
    int          lat_f = 0;
    int          lat_m = 0;
    bit          mem_phase = 1'b0;
    logic [11:0] pc = 12'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, advance PC model, drive mem_ready for the next posedge.
    task automatic cyc();
        logic strobe;
        @(negedge clk);
        chk("excl_pe_ir", 32'(bus.pc_enable & bus.ir_load), 32'd0);
        chk("excl_rd_wr", 32'(bus.mem_read & bus.mem_write), 32'd0);
        if (bus.pc_clear) pc = 12'h000;
        else if (bus.pc_enable) pc = bus.addr_select ? pc + bus.jump_offset : pc + 12'd1;
        strobe = bus.mem_read | bus.mem_write;
        if (strobe) hi_cnt++;
        else hi_cnt = 0;
        if (strobe) bus.mem_ready = (hi_cnt > (mem_phase ? lat_m : lat_f));
        else bus.mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic release_clear();
        clear = 1'b0;
        @(posedge clk);
        #1;
        chk("pc_clear_released", 32'(bus.pc_clear), 32'd0);
        chk("fetch_read_start", 32'(bus.mem_read), 32'd1);
        chk("fetch_state", 32'(bus.state), 32'd0);
    endtask

    task automatic reset_seq();
        clear = 1'b1;
        cyc();
        cyc();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc_clear", 32'(bus.pc_clear), 32'd1);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_ir_load", 32'(bus.ir_load), 32'd0);
        chk("rst_pc_enable", 32'(bus.pc_enable), 32'd0);
        chk("rst_addr_select", 32'(bus.addr_select), 32'd0);
        chk("rst_jump_offset", 32'(bus.jump_offset), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        release_clear();
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [11:0] off, input logic zf,
                             input logic nf, input int lf, input int lm);
        logic [11:0] pc0;
        logic [11:0] exp_pc;
        logic [11:0] jo_seen;
        logic        as_seen;
        bit          started, done, taken, is_mem, is_br, is_hlt;
        int          cycles, reads, writes, irl, exp_cycles;
        pc0 = pc;
        bus.opcode = op;
        bus.offset = off;
        bus.zero_flag = zf;
        bus.neg_flag = nf;
        lat_f = lf;
        lat_m = lm;
        mem_phase = 1'b0;
        started = 1'b0;
        done = 1'b0;
        cycles = 0;
        reads = 0;
        writes = 0;
        irl = 0;
        as_seen = 1'b0;
        jo_seen = 12'h000;
        for (int k = 0; k < 300 && !done; k++) begin
            cyc();
            if (bus.mem_read) started = 1'b1;
            if (started) begin
                cycles++;
                reads += int'(bus.mem_read);
                writes += int'(bus.mem_write);
                irl += int'(bus.ir_load);
            end
            if (bus.ir_load) mem_phase = 1'b1;
            if (bus.pc_enable) begin
                as_seen = bus.addr_select;
                jo_seen = bus.jump_offset;
                done = 1'b1;
            end
            if (bus.halted) done = 1'b1;
        end
        chk("instr_completes", 32'(done), 32'd1);

        is_mem = (op == OP_LD) || (op == OP_ST);
        is_br  = (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BLT);
        is_hlt = (op == OP_HLT);
        taken  = (op == OP_JMP) || (op == OP_BEQ && zf) || (op == OP_BLT && nf);
        if (is_hlt) exp_cycles = lf + 3;
        else if (is_br) exp_cycles = lf + 3;
        else if (is_mem) exp_cycles = lf + 1 + 1 + lm + 1 + 1;
        else exp_cycles = lf + 4;
        exp_pc = is_hlt ? pc0 : (taken ? pc0 + off : pc0 + 12'd1);

        chk("latency", 32'(cycles), 32'(exp_cycles));
        chk("ir_load_count", 32'(irl), 32'd1);
        chk("read_cycles", 32'(reads), 32'(lf + 1 + ((op == OP_LD) ? lm + 1 : 0)));
        chk("write_cycles", 32'(writes), 32'((op == OP_ST) ? lm + 1 : 0));
        chk("halted", 32'(bus.halted), 32'(is_hlt));
        chk("pc_after", 32'(pc), 32'(exp_pc));
        if (!is_hlt) begin
            chk("addr_select", 32'(as_seen), 32'(taken));
            chk("jump_offset", 32'(jo_seen), 32'(taken ? off : 12'h000));
        end
    endtask

    logic [3:0] pool [8];
    bit         seen;

    initial begin
        pool = '{OP_ALU, OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BLT, 4'h9, 4'hC};
        clear = 1'b1;
        bus.opcode = 4'h0;
        bus.offset = 12'h000;
        bus.zero_flag = 1'b0;
        bus.neg_flag = 1'b0;
        bus.mem_ready = 1'b0;

        reset_seq();
        run_instr(OP_ALU, 12'h000, 1'b0, 1'b0, 2, 0);
        for (int i = 0; i < 4; i++) run_instr(OP_ALU, 12'h7AB, 1'b1, 1'b1, 0, 0);
        run_instr(OP_JMP, 12'h010, 1'b0, 1'b0, 1, 0);
        run_instr(OP_BEQ, 12'h002, 1'b0, 1'b1, 0, 0);
        run_instr(OP_BEQ, 12'h002, 1'b1, 1'b0, 0, 0);
        run_instr(OP_BLT, 12'h100, 1'b1, 1'b0, 0, 0);

        reset_seq();
        for (int i = 0; i < 4; i++) run_instr(OP_ALU, 12'h000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_BLT, 12'hFFE, 1'b0, 1'b1, 0, 0);
        run_instr(OP_LD, 12'h123, 1'b0, 1'b0, 0, 5);
        run_instr(OP_ST, 12'h456, 1'b0, 1'b0, 1, 3);
        run_instr(4'h9, 12'h00F, 1'b1, 1'b1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_instr(pool[$urandom_range(0, 7)], 12'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Clear while a load is stalled in MEMWAIT.
        bus.opcode = OP_LD;
        lat_f = 0;
        lat_m = 100;
        mem_phase = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc();
            if (bus.ir_load) mem_phase = 1'b1;
            if (bus.state == 3'd3) seen = 1'b1;
        end
        chk("reach_memwait", 32'(seen), 32'd1);
        cyc();
        cyc();
        chk("memwait_read_held", 32'(bus.mem_read), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        chk("async_clear_state", 32'(bus.state), 32'd0);
        chk("async_clear_read", 32'(bus.mem_read), 32'd0);
        chk("async_clear_pe", 32'(bus.pc_enable), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("no_pe_in_clear", 32'(bus.pc_enable), 32'd0);
        end
        chk("pc_cleared", 32'(pc), 32'd0);
        release_clear();
        run_instr(OP_ALU, 12'h000, 1'b0, 1'b0, 0, 0);

        run_instr(OP_HLT, 12'h000, 1'b0, 1'b0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("halt_halted", 32'(bus.halted), 32'd1);
            chk("halt_state", 32'(bus.state), 32'd5);
            chk("halt_strobes", 32'({bus.mem_read, bus.mem_write, bus.ir_load, bus.pc_enable}),
                32'd0);
        end
        reset_seq();
        run_instr(OP_ALU, 12'h000, 1'b0, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
